fpu_ss_scoreboard_mc: RTL and testbench

- Parametrised multi-channel dependency/commit scoreboard for the FPU subsystem.
- Sits between the input buffer pop side and the execution units (FPnew, LSU result path). Gates dispatch of one instruction per cycle.
- Tracks multiple outstanding writes per FP register with per-register counters, commit status per offload ID, and up to NUM_WB simultaneous writeback channels.
- Selects per-operand forwarding sources and flags protocol errors.

---
 rtl/fpu_ss_scoreboard_mc.sv | 187 ++++++++++++++++++
 tb/tb_fpu_ss_scoreboard_mc.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_ss_scoreboard_mc.sv
// Multi-channel dependency/commit scoreboard gating FPU subsystem dispatch.
// Tracks per-register pending writes, per-ID commit status and up to NUM_WB writebacks per cycle.
module fpu_ss_scoreboard_mc #(
    parameter int NUM_REGS     = 32,
    parameter int ID_W         = 4,
    parameter int NUM_WB       = 2,
    parameter int MAX_INFLIGHT = 8,
    parameter int FORWARDING   = 1,
    parameter int IN_ORDER     = 0,
    parameter int ALLOW_WAW    = 0,
    localparam int REG_AW      = $clog2(NUM_REGS),
    localparam int SEL_W       = (NUM_WB > 1) ? $clog2(NUM_WB) : 1,
    localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     disp_valid_i,
    output logic                     disp_ready_o,
    input  logic [ID_W-1:0]          disp_id_i,
    input  logic [3*REG_AW-1:0]      disp_rs_i,
    input  logic [2:0]               disp_rs_used_i,
    input  logic [REG_AW-1:0]        disp_rd_i,
    input  logic                     disp_rd_fp_i,
    input  logic                     commit_valid_i,
    input  logic [ID_W-1:0]          commit_id_i,
    input  logic                     commit_kill_i,
    output logic                     kill_o,
    input  logic [NUM_WB-1:0]        wb_valid_i,
    input  logic [NUM_WB-1:0]        wb_we_i,
    input  logic [NUM_WB*REG_AW-1:0] wb_rd_i,
    output logic [2:0]               fwd_o,
    output logic [3*SEL_W-1:0]       fwd_sel_o,
    output logic [CNT_W-1:0]         inflight_o,
    output logic                     err_o
);

    localparam int NUM_IDS = 2 ** ID_W;
    localparam int PW      = $clog2(NUM_WB + 1);
    localparam int AW      = ((CNT_W > PW) ? CNT_W : PW) + 1;

    logic [CNT_W-1:0]  cnt_reg [NUM_REGS];
    logic [CNT_W-1:0]  cnt_next [NUM_REGS];
    logic [CNT_W-1:0]  cnt_aft_wb [NUM_REGS];
    logic [NUM_REGS-1:0] uflow;
    logic [NUM_IDS-1:0] cbit_reg, cbit_next;
    logic [CNT_W-1:0]  inflight_reg, inflight_next;
    logic              err_reg, err_next;

    logic [REG_AW-1:0] wb_rd [NUM_WB];
    logic [NUM_WB-1:0] wb_hit;
    logic [PW-1:0]     wb_pop;
    logic [AW-1:0]     infl_aft_wb;
    logic [AW-1:0]     infl_sum;
    logic [2:0]        fwd;
    logic [2:0]        raw;
    logic              waw, cap_ok, order_ok;
    logic              commit_set, committed, kill, ready_int, fire;

    assign wb_hit = wb_valid_i & wb_we_i;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WB; gi++) begin : g_wb
            assign wb_rd[gi] = wb_rd_i[gi*REG_AW +: REG_AW];
        end
    endgenerate

    always_comb begin
        wb_pop = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            wb_pop = wb_pop + PW'(wb_valid_i[k]);
        end
    end

    // Per-register counter update: dispatch increment and writeback decrements net out.
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_cnt
            logic [PW-1:0] dec;
            logic [AW-1:0] cnt_ext, dec_ext, inc_ext, sum;

            always_comb begin
                dec = '0;
                for (int k = 0; k < NUM_WB; k++) begin
                    if (wb_hit[k] && (wb_rd[k] == REG_AW'(gi))) begin
                        dec = dec + PW'(1);
                    end
                end
            end

            assign cnt_ext = AW'(cnt_reg[gi]);
            assign dec_ext = AW'(dec);
            assign inc_ext = AW'(fire && disp_rd_fp_i && (disp_rd_i == REG_AW'(gi)));
            assign sum     = cnt_ext + inc_ext;
            assign uflow[gi]      = (dec_ext > sum);
            assign cnt_next[gi]   = uflow[gi] ? '0 : CNT_W'(sum - dec_ext);
            assign cnt_aft_wb[gi] = (dec_ext > cnt_ext) ? '0 : CNT_W'(cnt_ext - dec_ext);
        end
    endgenerate

    // Operand hazard check; the lowest-numbered matching channel wins the forward.
    generate
        for (gi = 0; gi < 3; gi++) begin : g_opd
            logic [REG_AW-1:0] rs;
            logic              hit;
            logic [SEL_W-1:0]  sel;

            assign rs = disp_rs_i[gi*REG_AW +: REG_AW];

            always_comb begin
                hit = 1'b0;
                sel = '0;
                for (int k = NUM_WB - 1; k >= 0; k--) begin
                    if (wb_hit[k] && (wb_rd[k] == rs)) begin
                        hit = 1'b1;
                        sel = SEL_W'(k);
                    end
                end
            end

            assign fwd[gi] = (FORWARDING != 0) && disp_rs_used_i[gi]
                           && (cnt_reg[rs] == CNT_W'(1)) && hit;
            assign raw[gi] = disp_rs_used_i[gi] && (cnt_reg[rs] != '0) && !fwd[gi];
            assign fwd_sel_o[gi*SEL_W +: SEL_W] = sel;
        end
    endgenerate

    assign infl_aft_wb = (AW'(wb_pop) > AW'(inflight_reg)) ? '0
                       : AW'(inflight_reg) - AW'(wb_pop);
    assign cap_ok   = (infl_aft_wb < AW'(MAX_INFLIGHT));
    assign order_ok = (IN_ORDER == 0) || (infl_aft_wb == '0);
    assign waw      = (ALLOW_WAW == 0) && disp_rd_fp_i && (cnt_aft_wb[disp_rd_i] != '0);

    assign commit_set = commit_valid_i && !commit_kill_i;
    assign committed  = cbit_reg[disp_id_i] || (commit_set && (commit_id_i == disp_id_i));
    assign kill       = disp_valid_i && commit_valid_i && commit_kill_i && (commit_id_i == disp_id_i);

    assign ready_int = disp_valid_i && committed && !kill && (raw == 3'b000)
                     && !waw && cap_ok && order_ok;

    // Combinational outputs are forced low while reset is asserted.
    assign disp_ready_o = ready_int && rst_ni;
    assign kill_o       = kill && rst_ni;
    assign fwd_o        = fwd & {3{rst_ni}};
    assign fire         = disp_ready_o;

    // A dispatch consumes its commit bit even when that commit arrives this cycle.
    always_comb begin
        cbit_next = cbit_reg;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (fire && (disp_id_i == ID_W'(i))) begin
                cbit_next[i] = 1'b0;
            end else if (commit_set && (commit_id_i == ID_W'(i))) begin
                cbit_next[i] = 1'b1;
            end
        end
    end

    assign infl_sum      = AW'(inflight_reg) + AW'(fire);
    assign inflight_next = (AW'(wb_pop) > infl_sum) ? '0 : CNT_W'(infl_sum - AW'(wb_pop));

    assign err_next = err_reg
                    || (uflow != '0)
                    || ((wb_valid_i != '0) && (inflight_reg == '0) && !fire)
                    || (commit_set && cbit_reg[commit_id_i]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_reg[r] <= '0;
            end
            cbit_reg     <= '0;
            inflight_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_reg[r] <= cnt_next[r];
            end
            cbit_reg     <= cbit_next;
            inflight_reg <= inflight_next;
            err_reg      <= err_next;
        end
    end

    assign inflight_o = inflight_reg;
    assign err_o      = err_reg;

endmodule

// File: tb/tb_fpu_ss_scoreboard_mc.sv
// Directed bench for fpu_ss_scoreboard_mc: default instance plus an ALLOW_WAW=1 instance on shared stimulus.
module tb_fpu_ss_scoreboard_mc;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b0;
    logic        disp_valid;
    logic [3:0]  disp_id;
    logic [14:0] disp_rs;
    logic [2:0]  disp_rs_used;
    logic [4:0]  disp_rd;
    logic        disp_rd_fp;
    logic        commit_valid;
    logic [3:0]  commit_id;
    logic        commit_kill;
    logic [1:0]  wb_valid;
    logic [1:0]  wb_we;
    logic [9:0]  wb_rd;

    logic        ready_d, kill_d, err_d;
    logic [2:0]  fwd_d, sel_d;
    logic [3:0]  infl_d;
    logic        ready_w, kill_w, err_w;
    logic [2:0]  fwd_w, sel_w;
    logic [3:0]  infl_w;

    int vecs = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    fpu_ss_scoreboard_mc u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .disp_valid_i(disp_valid), .disp_ready_o(ready_d), .disp_id_i(disp_id),
        .disp_rs_i(disp_rs), .disp_rs_used_i(disp_rs_used), .disp_rd_i(disp_rd),
        .disp_rd_fp_i(disp_rd_fp), .commit_valid_i(commit_valid), .commit_id_i(commit_id),
        .commit_kill_i(commit_kill), .kill_o(kill_d), .wb_valid_i(wb_valid), .wb_we_i(wb_we),
        .wb_rd_i(wb_rd), .fwd_o(fwd_d), .fwd_sel_o(sel_d), .inflight_o(infl_d), .err_o(err_d)
    );

    fpu_ss_scoreboard_mc #(.ALLOW_WAW(1)) u_waw (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .disp_valid_i(disp_valid), .disp_ready_o(ready_w), .disp_id_i(disp_id),
        .disp_rs_i(disp_rs), .disp_rs_used_i(disp_rs_used), .disp_rd_i(disp_rd),
        .disp_rd_fp_i(disp_rd_fp), .commit_valid_i(commit_valid), .commit_id_i(commit_id),
        .commit_kill_i(commit_kill), .kill_o(kill_w), .wb_valid_i(wb_valid), .wb_we_i(wb_we),
        .wb_rd_i(wb_rd), .fwd_o(fwd_w), .fwd_sel_o(sel_w), .inflight_o(infl_w), .err_o(err_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        disp_valid = 0; disp_id = 0; disp_rs = 0; disp_rs_used = 0; disp_rd = 0; disp_rd_fp = 0;
        commit_valid = 0; commit_id = 0; commit_kill = 0;
        wb_valid = 0; wb_we = 0; wb_rd = 0;
    endtask

    task automatic head(input logic [3:0] id, input logic [4:0] rd, input logic fp, input logic cmt);
        disp_valid = 1; disp_id = id; disp_rd = rd; disp_rd_fp = fp;
        if (cmt) begin
            commit_valid = 1; commit_id = id; commit_kill = 0;
        end
    endtask

    task automatic rs(input int n, input logic [4:0] r);
        disp_rs[n*5 +: 5] = r;
        disp_rs_used[n] = 1'b1;
    endtask

    task automatic wb(input int k, input logic [4:0] r, input logic we);
        wb_valid[k] = 1'b1;
        wb_we[k] = we;
        wb_rd[k*5 +: 5] = r;
    endtask

    task automatic step(input string what);
        @(posedge clk_i);
        #1;
        $display("step %-12s infl=%0d/%0d err=%0b/%0b", what, infl_d, infl_w, err_d, err_w);
        idle();
    endtask

    initial begin
        idle();
        #2;
        // Reset: outputs held low even with a committed valid head present
        head(0, 0, 0, 1);
        #1;
        chk("rst_ready", ready_d, 0);
        chk("rst_kill", kill_d, 0);
        chk("rst_fwd", fwd_d, 0);
        chk("rst_infl", infl_d, 0);
        chk("rst_err", err_d, 0);
        idle();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Commit ID 3, then dispatch ID 3 writing f5
        commit_valid = 1; commit_id = 3;
        step("commit3");
        head(3, 5, 1, 0);
        #1 chk("d3_ready", ready_d, 1);
        step("disp3");
        chk("d3_infl", infl_d, 1);
        head(3, 0, 0, 0);
        #1 chk("cbit3_clear", ready_d, 0);
        idle();
        head(4, 0, 0, 1); rs(0, 5);
        #1 chk("raw_f5", ready_d, 0);
        chk("raw_f5_fwd", fwd_d, 0);
        step("commit4");

        // Reader of f5 forwarded from channel 1
        head(4, 0, 0, 0); rs(0, 5); wb(1, 5, 1);
        #1 chk("fwd1_fwd", fwd_d, 3'b001);
        chk("fwd1_sel", sel_d, 3'b001);
        chk("fwd1_ready", ready_d, 1);
        step("disp4_fwd");
        chk("fwd1_infl", infl_d, 1);
        head(5, 5, 1, 1); rs(1, 5);
        #1 chk("f5_free", ready_d, 1);
        step("disp5");
        chk("d5_infl", infl_d, 2);
        head(6, 0, 0, 1); rs(0, 5); rs(2, 5); wb(0, 5, 1);
        #1 chk("fwd0_fwd", fwd_d, 3'b101);
        chk("fwd0_sel", sel_d, 3'b000);
        chk("fwd0_ready", ready_d, 1);
        step("disp6_fwd");
        chk("d6_infl", infl_d, 2);

        // Kill of head ID 2
        head(2, 0, 0, 0); commit_valid = 1; commit_id = 2; commit_kill = 1;
        #1 chk("kill_kill", kill_d, 1);
        chk("kill_ready", ready_d, 0);
        step("kill2");
        chk("kill_infl", infl_d, 2);
        chk("kill_err", err_d, 0);
        head(2, 0, 0, 0);
        #1 chk("cbit2_unch", ready_d, 0);
        commit_valid = 1; commit_id = 2;
        #1 chk("commit2_ready", ready_d, 1);
        step("disp2");

        // Fill to capacity
        for (int i = 0; i < 5; i++) begin
            head(4'(8 + i), 0, 0, 1);
            step("fill");
        end
        chk("full_infl", infl_d, 8);
        head(13, 0, 0, 1);
        #1 chk("full_ready", ready_d, 0);
        wb(0, 0, 0);
        #1 chk("full_wb_ready", ready_d, 1);
        step("disp_full_wb");
        chk("full_wb_infl", infl_d, 8);
        chk("full_wb_err", err_d, 0);
        for (int i = 0; i < 4; i++) begin
            wb(0, 0, 0); wb(1, 0, 0);
            step("drain");
        end
        chk("drain_infl", infl_d, 0);
        chk("drain_err", err_d, 0);

        // WAW on f7
        head(1, 7, 1, 1);
        step("disp1_f7");
        chk("f7_infl", infl_d, 1);
        head(0, 7, 1, 1);
        #1 chk("waw_stall", ready_d, 0);
        chk("waw_allowed", ready_w, 1);
        wb(0, 7, 1);
        #1 chk("waw_wb_ready", ready_d, 1);
        step("disp0_f7");
        chk("waw_infl", infl_d, 1);

        // Two pending writers to f7 in the ALLOW_WAW instance
        head(1, 7, 1, 1);
        #1 chk("w2_stall_d", ready_d, 0);
        chk("w2_ready_w", ready_w, 1);
        step("w_disp1_f7");
        chk("w2_infl_w", infl_w, 2);
        head(0, 0, 0, 1); rs(0, 7); wb(0, 7, 1);
        #1 chk("w2_nofwd", fwd_w, 3'b000);
        chk("w2_ready", ready_w, 0);
        step("w_wb1");
        head(0, 0, 0, 0); rs(0, 7); wb(1, 7, 1);
        #1 chk("w1_fwd", fwd_w, 3'b001);
        chk("w1_sel", sel_w, 3'b001);
        chk("w1_ready", ready_w, 1);
        step("w_wb2");
        chk("w1_infl_w", infl_w, 1);
        chk("uflow_err", err_d, 1);
        chk("w_err", err_w, 0);
        step("idle");
        chk("err_sticky", err_d, 1);

        // Reset mid-traffic clears counters, inflight and err
        head(5, 9, 1, 1);
        step("disp5_f9");
        head(6, 0, 0, 1); rs(0, 9);
        #1 chk("f9_raw", ready_w, 0);
        rst_ni = 1'b0;
        #1 chk("mrst_err", err_d, 0);
        chk("mrst_infl_d", infl_d, 0);
        chk("mrst_infl_w", infl_w, 0);
        chk("mrst_ready", ready_d, 0);
        rst_ni = 1'b1;
        #1 chk("mrst_cnt_clr", ready_d, 1);
        step("disp6");
        chk("post_rst_infl", infl_d, 1);

        // Two channels hit the same register: channel 0 wins, count underflows
        head(1, 4, 1, 1);
        step("disp1_f4");
        head(2, 0, 0, 1); rs(1, 4); wb(0, 4, 1); wb(1, 4, 1);
        #1 chk("prio_fwd", fwd_d, 3'b010);
        chk("prio_sel", sel_d, 3'b000);
        chk("prio_ready", ready_d, 1);
        chk("prio_err_pre", err_d, 0);
        step("disp2_prio");
        chk("prio_err", err_d, 1);
        chk("prio_infl", infl_d, 1);

        // Writeback with nothing in flight
        rst_ni = 1'b0;
        #2 rst_ni = 1'b1;
        #1 wb(0, 0, 0);
        step("wb_empty");
        chk("empty_wb_err", err_d, 1);
        rst_ni = 1'b0;
        #2 rst_ni = 1'b1;
        #1 head(3, 0, 0, 1); wb(0, 0, 0);
        step("disp_wb_empty");
        chk("fire_wb_err", err_d, 0);
        chk("fire_wb_infl", infl_d, 0);

        // Double commit of one ID
        commit_valid = 1; commit_id = 4;
        step("commit4a");
        chk("commit1_err", err_d, 0);
        commit_valid = 1; commit_id = 4;
        step("commit4b");
        chk("dbl_commit_err", err_d, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
